// File: rtl/pe_psum_accum_bank.sv
// pe_psum_accum_bank
//   Multi-channel partial-sum register bank behind the fused PE array.
//   Each accepted beat carries NUM_CH signed PE sums. The bank adds up a
//   programmable number of beats (the window) per channel with saturation.
//   It then holds the result on a valid/ready output until it is consumed.
//   A window length of 1 turns the bank into a plain per-channel pipeline
//   register.
//
// Ports
//   clk, reset  rising-edge clock, synchronous active-high reset
//   acc_len     beats per window, sampled on the first beat of a window (0 -> 1)
//   flush       closes an open window early; only acted on while busy
//   in_valid    input beat valid
//   in_ready    bank can take a beat
//   in_sum      lane k = in_sum[k*IN_W +: IN_W], two's complement
//   out_valid   result valid
//   out_ready   downstream takes the result
//   out_sum     lane k = out_sum[k*ACC_W +: ACC_W], registered accumulators
//   out_sat     lane k clamped at least once in this window
//   busy        window open (ACCUM)
//
// Handshake: a beat transfers on a clock edge where in_valid && in_ready.
// A result transfers on an edge where out_valid && out_ready. A producer
// must not make valid depend on ready. in_ready depends only on reset,
// state and out_ready. out_sum/out_sat hold steady while a result is pending.
module pe_psum_accum_bank #(
   parameter int IN_W   = 20,
   parameter int ACC_W  = 24,
   parameter int NUM_CH = 4,
   parameter int LEN_W  = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [LEN_W-1:0]          acc_len,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NUM_CH*IN_W-1:0]    in_sum,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NUM_CH*ACC_W-1:0]   out_sum,
   output logic [NUM_CH-1:0]         out_sat,
   output logic                      busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t                        state;
   logic [NUM_CH-1:0][ACC_W-1:0]  acc;
   logic [NUM_CH-1:0]             sat;
   logic [LEN_W-1:0]              cnt;
   logic [LEN_W-1:0]              len;

   logic [NUM_CH-1:0][ACC_W-1:0]  ext_in;
   logic [NUM_CH-1:0][ACC_W-1:0]  add_sat;
   logic [NUM_CH-1:0]             ovf;

   logic                          accept;
   logic                          start;
   logic [LEN_W-1:0]              len_eff;
   logic [LEN_W:0]                cnt_inc;

   localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   assign in_ready  = !reset && (state != HOLD || out_ready);
   assign accept    = in_valid && in_ready;
   // A beat opens a new window from IDLE, or from HOLD when the pending
   // result leaves on the same edge (in_ready in HOLD implies out_ready).
   assign start     = accept && (state == IDLE || state == HOLD);
   assign len_eff   = (acc_len == '0) ? LEN_W'(1) : acc_len;
   // One bit wider so len = 2^LEN_W-1 can never wrap the comparison.
   assign cnt_inc   = {1'b0, cnt} + (LEN_W+1)'(1);

   assign out_valid = (state == HOLD);
   assign busy      = (state == ACCUM);
   assign out_sum   = acc;
   assign out_sat   = sat;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      logic [IN_W-1:0]  lane_in;
      logic [ACC_W:0]   wide;

      assign lane_in = in_sum[k*IN_W +: IN_W];

      if (ACC_W > IN_W) begin : g_ext
         assign ext_in[k] = {{(ACC_W-IN_W){lane_in[IN_W-1]}}, lane_in};
      end else begin : g_noext
         assign ext_in[k] = lane_in;
      end

      // Add in ACC_W+1 bits. The two top bits differ exactly when the
      // ACC_W-bit result would overflow. The top bit then gives the clamp
      // direction.
      assign wide       = {acc[k][ACC_W-1], acc[k]} + {ext_in[k][ACC_W-1], ext_in[k]};
      assign ovf[k]     = wide[ACC_W] ^ wide[ACC_W-1];
      assign add_sat[k] = ovf[k] ? (wide[ACC_W] ? SAT_MIN : SAT_MAX) : wide[ACC_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         acc   <= '0;
         sat   <= '0;
         cnt   <= '0;
         len   <= LEN_W'(1);
      end else begin
         if (start) begin
            acc   <= ext_in;
            sat   <= '0;
            cnt   <= LEN_W'(1);
            len   <= len_eff;
            state <= (len_eff == LEN_W'(1)) ? HOLD : ACCUM;
         end else begin
            case (state)
               ACCUM: begin
                  if (accept) begin
                     acc <= add_sat;
                     sat <= sat | ovf;
                     cnt <= cnt_inc[LEN_W-1:0];
                  end
                  // A flush that arrives together with a beat closes the
                  // window after that beat has been added.
                  if ((accept && cnt_inc == {1'b0, len}) || flush)
                     state <= HOLD;
               end
               HOLD: begin
                  // Result leaves with no new beat. The accumulators keep
                  // their value, so out_sum shows the last result.
                  if (out_ready)
                     state <= IDLE;
               end
               default: state <= state;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pe_psum_accum_bank.sv
module tb_pe_psum_accum_bank;

   localparam int IN_W   = 20;
   localparam int ACC_W  = 24;
   localparam int NUM_CH = 4;
   localparam int LEN_W  = 8;
   localparam int SW     = NUM_CH*ACC_W;
   localparam int EW     = NUM_CH + SW;
   localparam longint MAXV = (64'sd1 <<< (ACC_W-1)) - 1;
   localparam longint MINV = -(64'sd1 <<< (ACC_W-1));

   logic                    clk;
   logic                    reset;
   logic [LEN_W-1:0]        acc_len;
   logic                    flush;
   logic                    in_valid;
   logic                    in_ready;
   logic [NUM_CH*IN_W-1:0]  in_sum;
   logic                    out_valid;
   logic                    out_ready;
   logic [SW-1:0]           out_sum;
   logic [NUM_CH-1:0]       out_sat;
   logic                    busy;

   int n_checks = 0;
   int n_errors = 0;

   logic [EW-1:0] exp_q[$];

   longint            m_acc [NUM_CH];
   logic [NUM_CH-1:0] m_sat;

   pe_psum_accum_bank #(
      .IN_W(IN_W), .ACC_W(ACC_W), .NUM_CH(NUM_CH), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .reset(reset), .acc_len(acc_len), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_sat(out_sat), .busy(busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_beat(input logic [NUM_CH*IN_W-1:0] v, input bit first);
      for (int k = 0; k < NUM_CH; k++) begin
         logic signed [IN_W-1:0] xs;
         longint x, s;
         xs = v[k*IN_W +: IN_W];
         x  = longint'(xs);
         if (first) begin
            m_acc[k] = x;
            m_sat[k] = 1'b0;
         end else begin
            s = m_acc[k] + x;
            if (s > MAXV) begin s = MAXV; m_sat[k] = 1'b1; end
            else if (s < MINV) begin s = MINV; m_sat[k] = 1'b1; end
            m_acc[k] = s;
         end
      end
   endtask

   task automatic model_push();
      logic [SW-1:0] e;
      for (int k = 0; k < NUM_CH; k++) begin
         longint a;
         a = m_acc[k];
         e[k*ACC_W +: ACC_W] = a[ACC_W-1:0];
      end
      exp_q.push_back({m_sat, e});
   endtask

   // ---------------- drivers ----------------
   // Hold one beat until accepted, bounded by a cycle budget.
   task automatic send_beat(input logic [NUM_CH*IN_W-1:0] v, input logic fl);
      int waited;
      in_valid = 1'b1;
      in_sum   = v;
      flush    = fl;
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      if (waited >= 50) check("in_ready_timeout", 128'(in_ready), 128'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic send_window(input int lenf, input int nb, input bit fl_last,
                              input bit rnd, input logic [NUM_CH*IN_W-1:0] v,
                              input bit push_model);
      logic [NUM_CH*IN_W-1:0] bv;
      acc_len = LEN_W'(lenf);
      for (int i = 0; i < nb; i++) begin
         bv = v;
         if (rnd)
            for (int k = 0; k < NUM_CH; k++)
               bv[k*IN_W +: IN_W] = IN_W'($urandom_range(0, (1 << IN_W) - 1));
         model_beat(bv, i == 0);
         send_beat(bv, fl_last && (i == nb - 1));
      end
      if (push_model) model_push();
   endtask

   function automatic logic [NUM_CH*IN_W-1:0] lane0(input logic [IN_W-1:0] x);
      logic [NUM_CH*IN_W-1:0] r;
      r = '0;
      r[IN_W-1:0] = x;
      return r;
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 128'(1), 128'(0));
         end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("out_sum", 128'(out_sum), 128'(e[SW-1:0]));
            check("out_sat", 128'(out_sat), 128'(e[EW-1 -: NUM_CH]));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [SW-1:0] held;
      reset     = 1'b1;
      acc_len   = LEN_W'(1);
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_sum    = '0;
      out_ready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_busy",      128'(busy),      128'(0));
      check("rst_out_sum",   128'(out_sum),   128'(0));
      check("rst_out_sat",   128'(out_sat),   128'(0));
      check("rst_in_ready",  128'(in_ready),  128'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;

      // 1. pass-through: one result per cycle, one cycle after each beat
      for (int i = 0; i < 4; i++) begin
         send_window(1, 1, 1'b0, 1'b0, lane0(20'h00005), 1'b1);
         check("t1_out_valid", 128'(out_valid), 128'(1));
         check("t1_in_ready",  128'(in_ready),  128'(1));
      end
      // acc_len = 0 behaves as 1
      send_window(0, 1, 1'b0, 1'b0, lane0(20'h00009), 1'b1);
      check("t1_len0_valid", 128'(out_valid), 128'(1));
      @(posedge clk); #1;

      // 2. accumulate four beats across all lanes (fixed expected result)
      send_window(4, 4, 1'b0, 1'b0, {20'h80000, 20'h7FFFF, 20'hFFFFD, 20'h0000A}, 1'b0);
      exp_q.push_back({4'b0000, 24'hE00000, 24'h1FFFFC, 24'hFFFFF4, 24'h000028});
      check("t2_out_valid", 128'(out_valid), 128'(1));
      @(posedge clk); #1;

      // 3. saturation on lane 0 only
      send_window(32, 32, 1'b0, 1'b0, lane0(20'h7FFFF), 1'b0);
      exp_q.push_back({4'b0001, 24'h000000, 24'h000000, 24'h000000, 24'h7FFFFF});
      @(posedge clk); #1;

      // 4. backpressure
      out_ready = 1'b0;
      send_window(1, 1, 1'b0, 1'b0, lane0(20'h00123), 1'b1);
      held = exp_q[0][SW-1:0];
      repeat (5) begin
         @(negedge clk);
         check("t4_out_valid", 128'(out_valid), 128'(1));
         check("t4_in_ready",  128'(in_ready),  128'(0));
         check("t4_stable",    128'(out_sum),   128'(held));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send_window(1, 1, 1'b0, 1'b0, lane0(20'h00456), 1'b1);
      check("t4_next_valid", 128'(out_valid), 128'(1));
      @(posedge clk); #1;

      // 5. flush with the fourth beat of an 8-beat window
      send_window(8, 4, 1'b1, 1'b0, lane0(20'h00002), 1'b0);
      exp_q.push_back({4'b0000, 24'h000000, 24'h000000, 24'h000000, 24'h000008});
      check("t5_out_valid", 128'(out_valid), 128'(1));
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("t5_idle_flush_valid", 128'(out_valid), 128'(0));
      check("t5_idle_flush_busy",  128'(busy),      128'(0));

      // 6. reset in the middle of a window
      send_window(4, 2, 1'b0, 1'b0, lane0(20'h00064), 1'b0);
      check("t6_busy", 128'(busy), 128'(1));
      reset = 1'b1;
      @(negedge clk);
      check("t6_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      check("t6_out_valid", 128'(out_valid), 128'(0));
      check("t6_out_sum",   128'(out_sum),   128'(0));
      check("t6_busy_clr",  128'(busy),      128'(0));
      send_window(2, 2, 1'b0, 1'b0, lane0(20'h00007), 1'b0);
      exp_q.push_back({4'b0000, 24'h000000, 24'h000000, 24'h000000, 24'h00000E});
      @(posedge clk); #1;

      // random windows, some closed early by flush
      for (int w = 0; w < 20; w++) begin
         int lenf, nb;
         bit fl;
         lenf = $urandom_range(1, 6);
         fl   = (lenf >= 3) && ($urandom_range(0, 2) == 0);
         nb   = fl ? $urandom_range(2, lenf - 1) : lenf;
         send_window(lenf, nb, fl, 1'b1, '0, 1'b1);
      end

      repeat (5) @(posedge clk);
      @(negedge clk);
      check("drain", 128'(exp_q.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global time limit so the run always ends
   initial begin
      #500000;
      check("global_timeout", 128'(1), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
